// File: rtl/usb_rx_nrzi_destuff.sv
// USB receive front end: NRZI decode, bit-unstuffing, SE0/EOP qualification and line-error detection.
// Optional saturating error counter on port err_count when USB_RX_ERR_COUNT_EN is defined.
module usb_rx_nrzi_destuff #(
  parameter int unsigned STUFF_LEN   = 6,
  parameter int unsigned EOP_SE0_MIN = 2,
  parameter bit          IDLE_DP     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_plus,
  input  logic       d_minus,
  input  logic       shift_enable,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       eop,
  output logic       rx_err,
  output logic       idle
`ifdef USB_RX_ERR_COUNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int unsigned OC_W = $clog2(STUFF_LEN + 1);
  localparam int unsigned SC_W = $clog2(EOP_SE0_MIN + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_SE0    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            prev_dp_q, prev_dp_d;
  logic [OC_W-1:0] ones_cnt_q, ones_cnt_d;
  logic [SC_W-1:0] se0_cnt_q, se0_cnt_d;
  logic            bit_out_q, bit_out_d;
  logic            bit_valid_q, bit_valid_d;
  logic            eop_q, eop_d;
  logic            rx_err_q, rx_err_d;
  logic            idle_q, idle_d;

  logic line_j_s, line_k_s, line_se0_s, line_se1_s, decoded_s;

  assign line_j_s   = (d_plus == IDLE_DP) && (d_minus == ~IDLE_DP);
  assign line_k_s   = (d_plus == ~IDLE_DP) && (d_minus == IDLE_DP);
  assign line_se0_s = (d_plus == 1'b0) && (d_minus == 1'b0);
  assign line_se1_s = (d_plus == 1'b1) && (d_minus == 1'b1);
  assign decoded_s  = (d_plus == prev_dp_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      prev_dp_q   <= IDLE_DP;
      ones_cnt_q  <= {OC_W{1'b0}};
      se0_cnt_q   <= {SC_W{1'b0}};
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      eop_q       <= 1'b0;
      rx_err_q    <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      prev_dp_q   <= prev_dp_d;
      ones_cnt_q  <= ones_cnt_d;
      se0_cnt_q   <= se0_cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      eop_q       <= eop_d;
      rx_err_q    <= rx_err_d;
      idle_q      <= idle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (shift_enable) begin
      case (state_q)
        S_IDLE: begin
          if (line_k_s) state_d = S_ACTIVE;
          else          state_d = S_IDLE;
        end
        S_ACTIVE: begin
          if (line_se0_s)      state_d = S_SE0;
          else if (line_se1_s) state_d = S_IDLE;
          else                 state_d = S_ACTIVE;
        end
        S_SE0: begin
          if (line_se0_s) state_d = S_SE0;
          else            state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Pulse outputs and datapath registers; any exit to IDLE restores the idle line context.
  always_comb begin
    bit_out_d   = 1'b0;
    bit_valid_d = 1'b0;
    eop_d       = 1'b0;
    rx_err_d    = 1'b0;
    prev_dp_d   = prev_dp_q;
    ones_cnt_d  = ones_cnt_q;
    se0_cnt_d   = se0_cnt_q;
    if (shift_enable) begin
      case (state_q)
        S_IDLE: begin
          if (line_k_s) begin
            bit_valid_d = 1'b1;
            prev_dp_d   = d_plus;
            ones_cnt_d  = {OC_W{1'b0}};
          end else if (line_se1_s) begin
            rx_err_d = 1'b1;
          end else begin
            rx_err_d = 1'b0;
          end
        end
        S_ACTIVE: begin
          if (line_j_s || line_k_s) begin
            prev_dp_d = d_plus;
            if (ones_cnt_q == OC_W'(STUFF_LEN)) begin
              ones_cnt_d = {OC_W{1'b0}};
              rx_err_d   = decoded_s;
            end else begin
              bit_valid_d = 1'b1;
              bit_out_d   = decoded_s;
              ones_cnt_d  = decoded_s ? (ones_cnt_q + OC_W'(1)) : {OC_W{1'b0}};
            end
          end else if (line_se0_s) begin
            se0_cnt_d = SC_W'(1);
          end else begin
            rx_err_d   = 1'b1;
            prev_dp_d  = IDLE_DP;
            ones_cnt_d = {OC_W{1'b0}};
            se0_cnt_d  = {SC_W{1'b0}};
          end
        end
        S_SE0: begin
          if (line_se0_s) begin
            if (se0_cnt_q < SC_W'(EOP_SE0_MIN)) se0_cnt_d = se0_cnt_q + SC_W'(1);
            else                                 se0_cnt_d = se0_cnt_q;
          end else begin
            if (line_j_s && (se0_cnt_q >= SC_W'(EOP_SE0_MIN))) eop_d = 1'b1;
            else                                                rx_err_d = 1'b1;
            prev_dp_d  = IDLE_DP;
            ones_cnt_d = {OC_W{1'b0}};
            se0_cnt_d  = {SC_W{1'b0}};
          end
        end
        default: begin
          prev_dp_d  = IDLE_DP;
          ones_cnt_d = {OC_W{1'b0}};
          se0_cnt_d  = {SC_W{1'b0}};
        end
      endcase
    end else begin
      bit_valid_d = 1'b0;
    end
  end

  always_comb begin
    idle_d = (state_d == S_IDLE);
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign eop       = eop_q;
  assign rx_err    = rx_err_q;
  assign idle      = idle_q;

`ifdef USB_RX_ERR_COUNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    if (rx_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    else                                  err_cnt_d = err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 8'd0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_usb_rx_nrzi_destuff.sv
// Self-checking bench for usb_rx_nrzi_destuff: directed steps plus random line traffic,
// compared every cycle against a symbol-level reference model.
module tb_usb_rx_nrzi_destuff;

  localparam int SJ = 0;
  localparam int SK = 1;
  localparam int S0 = 2;
  localparam int S1 = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_plus = 1'b1;
  logic       d_minus = 1'b0;
  logic       shift_enable = 1'b0;
  logic       bit_out, bit_valid, eop, rx_err, idle;
`ifdef USB_RX_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  usb_rx_nrzi_destuff dut (
    .clk          (clk),
    .rst          (rst),
    .d_plus       (d_plus),
    .d_minus      (d_minus),
    .shift_enable (shift_enable),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .eop          (eop),
    .rx_err       (rx_err),
    .idle         (idle)
`ifdef USB_RX_ERR_COUNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: symbol-level view of the line (J/K/SE0/SE1).
  int m_mode;    // 0 idle, 1 in packet, 2 inside SE0 run
  int m_last;    // last J/K symbol seen, J after idle
  int m_ones;
  int m_se0;
  int m_errs;
  bit exp_valid, exp_bit, exp_eop, exp_err, exp_idle;
  bit got [$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_go_idle();
    m_mode = 0;
    m_last = SJ;
    m_ones = 0;
    m_se0  = 0;
  endtask

  task automatic model_reset();
    model_go_idle();
    m_errs    = 0;
    exp_valid = 1'b0;
    exp_bit   = 1'b0;
    exp_eop   = 1'b0;
    exp_err   = 1'b0;
    exp_idle  = 1'b1;
  endtask

  task automatic model(input int sym, input bit se);
    bit d;
    exp_valid = 1'b0;
    exp_bit   = 1'b0;
    exp_eop   = 1'b0;
    exp_err   = 1'b0;
    if (se) begin
      if (m_mode == 0) begin
        if (sym == SK) begin
          exp_valid = 1'b1;
          m_mode = 1;
          m_last = SK;
          m_ones = 0;
        end else if (sym == S1) begin
          exp_err = 1'b1;
        end
      end else if (m_mode == 1) begin
        if (sym == SJ || sym == SK) begin
          d = (sym == m_last);
          m_last = sym;
          if (m_ones == 6) begin
            m_ones  = 0;
            exp_err = d;
          end else begin
            exp_valid = 1'b1;
            exp_bit   = d;
            m_ones    = d ? m_ones + 1 : 0;
          end
        end else if (sym == S0) begin
          m_mode = 2;
          m_se0  = 1;
        end else begin
          exp_err = 1'b1;
          model_go_idle();
        end
      end else begin
        if (sym == S0) begin
          m_se0++;
        end else begin
          if (sym == SJ && m_se0 >= 2) exp_eop = 1'b1;
          else                         exp_err = 1'b1;
          model_go_idle();
        end
      end
      if (exp_err && m_errs < 255) m_errs++;
      exp_idle = (m_mode == 0);
    end
  endtask

  task automatic drive(input int sym);
    case (sym)
      SJ:      begin d_plus = 1'b1; d_minus = 1'b0; end
      SK:      begin d_plus = 1'b0; d_minus = 1'b1; end
      S0:      begin d_plus = 1'b0; d_minus = 1'b0; end
      default: begin d_plus = 1'b1; d_minus = 1'b1; end
    endcase
  endtask

  task automatic cycle(input int sym, input bit se);
    drive(sym);
    shift_enable = se;
    model(sym, se);
    @(posedge clk);
    #1;
    chk("bit_valid", {7'd0, bit_valid}, {7'd0, exp_valid});
    if (exp_valid) chk("bit_out", {7'd0, bit_out}, {7'd0, exp_bit});
    chk("eop", {7'd0, eop}, {7'd0, exp_eop});
    chk("rx_err", {7'd0, rx_err}, {7'd0, exp_err});
    chk("idle", {7'd0, idle}, {7'd0, exp_idle});
`ifdef USB_RX_ERR_COUNT_EN
    chk("err_count", err_count, m_errs[7:0]);
`endif
    if (bit_valid === 1'b1) got.push_back(bit_out);
    @(negedge clk);
  endtask

  // One strobe followed by a quiet cycle, so every pulse must also drop again.
  task automatic send(input int sym);
    cycle(sym, 1'b1);
    cycle(sym, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    shift_enable = 1'b1;
    drive(SK);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_bit_valid", {7'd0, bit_valid}, 8'd0);
    chk("rst_bit_out", {7'd0, bit_out}, 8'd0);
    chk("rst_eop", {7'd0, eop}, 8'd0);
    chk("rst_rx_err", {7'd0, rx_err}, 8'd0);
    chk("rst_idle", {7'd0, idle}, 8'd1);
`ifdef USB_RX_ERR_COUNT_EN
    chk("rst_err_count", err_count, 8'd0);
`endif
    rst = 1'b0;
    shift_enable = 1'b0;
    drive(SJ);
    @(negedge clk);
  endtask

  initial begin
    bit sync_exp [10];
    bit stuff_exp [7];
    int r;
    sync_exp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    stuff_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle J line.
    got.delete();
    for (int i = 0; i < 8; i++) send(SJ);
    chk("idle_no_bits", 8'(got.size()), 8'd0);

    // SYNC then two more bits.
    got.delete();
    send(SK); send(SJ); send(SK); send(SJ);
    send(SK); send(SJ); send(SK); send(SK);
    send(SJ); send(SJ);
    chk("sync_count", 8'(got.size()), 8'd10);
    for (int i = 0; i < 10 && i < got.size(); i++) chk("sync_bit", {7'd0, got[i]}, {7'd0, sync_exp[i]});

    // Six 1s followed by a stuffed 0 that must be dropped.
    got.delete();
    send(SK);
    for (int i = 0; i < 6; i++) send(SK);
    send(SJ);
    chk("stuff_count", 8'(got.size()), 8'd7);
    for (int i = 0; i < 7 && i < got.size(); i++) chk("stuff_bit", {7'd0, got[i]}, {7'd0, stuff_exp[i]});

    // Seventh consecutive 1 is a stuff violation.
    for (int i = 0; i < 7; i++) send(SJ);

    // Qualified EOP, then a short SE0.
    send(S0); send(S0); send(SJ);
    send(SK); send(SJ); send(S0); send(SJ);

    // SE1 inside a packet, SE1 and SE0 while idle, SE0 followed by K.
    send(SK); send(SJ); send(S1);
    send(S1); send(S0); send(SJ);
    send(SK); send(S0); send(S0); send(S0); send(SK);

    // Reset mid-packet, then decoding restarts from the idle level.
    send(SK); send(SK); send(SJ);
    do_reset();
    got.delete();
    send(SK); send(SJ); send(SJ);
    chk("post_rst_count", 8'(got.size()), 8'd3);

    // Random traffic with back-to-back and sparse strobes.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r == 0) begin
        do_reset();
      end else begin
        r = int'($urandom_range(0, 99));
        cycle((r < 44) ? SJ : (r < 90) ? SK : (r < 97) ? S0 : S1, ($urandom_range(0, 9) < 7));
      end
    end

    // Long run of identical symbols: one stuff error every seventh strobe.
    do_reset();
    cycle(SK, 1'b1);
    for (int i = 0; i < 300 * 7; i++) cycle(SK, 1'b1);
    chk("forced_err_total", 8'(m_errs), 8'd255);
`ifdef USB_RX_ERR_COUNT_EN
    chk("err_count_sat", err_count, 8'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
